// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART-side signal bundle for uart_tx_arbiter
//
// Purpose: carries the byte-stream requester handshake and the SingleTxUART launch
// interface between the requesters/UART (master side) and the arbiter (slave side).
// Signals:
//   req[N_REQ]        requester i presents a valid byte on data[8*i+7:8*i]
//   last[N_REQ]       that byte ends requester i's frame
//   data[8*N_REQ]     flattened requester bytes
//   ack[N_REQ]        one-cycle pulse, byte of requester i consumed
//   grant[N_REQ]      one-hot current owner of the UART, 0 when free
//   uart_start        one-cycle launch pulse to the UART
//   uart_data[8]      byte launched, held until the next launch
//   uart_busy         UART shifting a byte
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   last;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               uart_start;
  logic [7:0]         uart_data;
  logic               uart_busy;

  modport master (
    output req, last, data, uart_busy,
    input  ack, grant, uart_start, uart_data
  );

  modport slave (
    input  req, last, data, uart_busy,
    output ack, grant, uart_start, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one SingleTxUART
//
// Purpose: grants the UART to one requester at a time for a whole frame (until the
// byte flagged last has shifted out), rotating priority after each frame. Watches
// the UART busy line for a missing response and the owner for stalls inside a frame.
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   bus        uart_tx_arbiter_if.slave: req/last/data/ack/grant, uart_start/uart_data/uart_busy
//   err_busy   one-cycle pulse, busy did not rise within BUSY_WAIT cycles of a launch
//   err_gap    one-cycle pulse, owner idle for GAP_TIMEOUT cycles mid-frame, frame abandoned
//   idle       1 while in IDLE with no grant outstanding
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int BUSY_WAIT   = 16,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic               err_busy,
  output logic               err_gap,
  output logic               idle
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (BUSY_WAIT > GAP_TIMEOUT) ? BUSY_WAIT : GAP_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [CW-1:0]  cnt;
  logic           is_last;

  logic [PW-1:0]  win_idx;
  logic           win_found;
  logic [PW-1:0]  ptr_next;

  // Round-robin pick: first pending requester at or above ptr, wrapping past N_REQ-1.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // After a frame ends (cleanly or by timeout) the requester after the owner gets top priority.
  assign ptr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      ptr            <= '0;
      gidx           <= '0;
      cnt            <= '0;
      is_last        <= 1'b0;
      bus.grant      <= '0;
      bus.ack        <= '0;
      bus.uart_start <= 1'b0;
      bus.uart_data  <= 8'h00;
      err_busy       <= 1'b0;
      err_gap        <= 1'b0;
      idle           <= 1'b1;
    end else begin
      // Pulse outputs default low; only the cases below raise them for one cycle.
      bus.ack        <= '0;
      bus.uart_start <= 1'b0;
      err_busy       <= 1'b0;
      err_gap        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (win_found) begin
            bus.grant <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            gidx      <= win_idx;
            idle      <= 1'b0;
            state     <= S_LAUNCH;
          end else begin
            idle <= 1'b1;
          end
        end

        // Byte is taken from the requester here; ack and start leave together so the
        // requester can move on to its next byte from the following cycle.
        S_LAUNCH: begin
          bus.uart_start <= 1'b1;
          bus.uart_data  <= bus.data[int'(gidx)*8 +: 8];
          bus.ack        <= bus.grant;
          is_last        <= bus.last[gidx];
          cnt            <= '0;
          state          <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (bus.uart_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CW'(BUSY_WAIT - 1)) begin
            err_busy  <= 1'b1;
            bus.grant <= '0;
            ptr       <= ptr_next;
            idle      <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (!bus.uart_busy) begin
            if (is_last) begin
              bus.grant <= '0;
              ptr       <= ptr_next;
              idle      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cnt   <= '0;
              state <= S_GAP;
            end
          end
        end

        // Owner keeps the UART between bytes; other requesters are not considered here.
        S_GAP: begin
          if (bus.req[gidx]) begin
            state <= S_LAUNCH;
          end else if (cnt == CW'(GAP_TIMEOUT - 1)) begin
            err_gap   <= 1'b1;
            bus.grant <= '0;
            ptr       <= ptr_next;
            idle      <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          bus.grant <= '0;
          idle      <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err_busy, err_gap, idle;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .BUSY_WAIT(16), .GAP_TIMEOUT(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .err_busy (err_busy),
    .err_gap  (err_gap),
    .idle     (idle)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester byte queues
  logic [7:0] q_byte [4][16];
  logic       q_last [4][16];
  int         q_head [4] = '{0, 0, 0, 0};
  int         q_tail [4] = '{0, 0, 0, 0};

  task automatic push(input int r, input logic [7:0] b, input logic l);
    q_byte[r][q_tail[r]] = b;
    q_last[r][q_tail[r]] = l;
    q_tail[r]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < 4; i++) if (q_head[i] < q_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Logs filled by the requester/UART model process
  int         cyc = 0;
  int         tx_n = 0;
  logic [7:0] tx_byte [64];
  logic [3:0] tx_grant [64];
  logic [3:0] tx_ack [64];
  int         tx_cyc [64];
  int         req_rise_cyc [4] = '{0, 0, 0, 0};
  int         grant_cyc = 0;
  int         n_eb = 0, eb_cyc = 0;
  int         n_eg = 0, eg_len = 0;
  logic [3:0] err_grant = '0;
  int         busy_fall_cyc = 0;
  logic [3:0] prev_grant = '0;
  logic       stub = 1'b0;
  logic       busy = 1'b0;
  int         bcnt = 0;

  // Requesters plus a behavioural SingleTxUART (80 clk per byte), all on the falling edge.
  initial begin
    bus.req = '0; bus.last = '0; bus.data = '0; bus.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.uart_start) begin
        chk("start_while_busy", {31'b0, busy}, 32'd0);
        chk("ack_at_start", {28'b0, bus.ack}, {28'b0, bus.grant});
        if (tx_n < 64) begin
          tx_byte[tx_n] = bus.uart_data;
          tx_grant[tx_n] = bus.grant;
          tx_ack[tx_n] = bus.ack;
          tx_cyc[tx_n] = cyc;
          tx_n++;
        end
        if (!stub) begin
          busy = 1'b1;
          bcnt = 80;
        end
      end else begin
        if (bus.ack != 4'b0) chk("ack_without_start", {28'b0, bus.ack}, 32'd0);
        if (busy) begin
          bcnt--;
          if (bcnt == 0) begin
            busy = 1'b0;
            busy_fall_cyc = cyc;
          end
        end
      end
      if (bus.grant != 4'b0) chk("grant_onehot", {31'b0, $onehot(bus.grant)}, 32'd1);
      if (bus.grant != 4'b0 && prev_grant == 4'b0) grant_cyc = cyc;
      prev_grant = bus.grant;
      if (err_busy) begin n_eb++; eb_cyc = cyc; err_grant = bus.grant; end
      if (err_gap) begin n_eg++; eg_len = cyc - busy_fall_cyc; err_grant = bus.grant; end
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) q_head[i]++;
      end
      for (int i = 0; i < 4; i++) begin
        logic nr;
        nr = (q_head[i] < q_tail[i]);
        if (nr && !bus.req[i]) req_rise_cyc[i] = cyc;
        bus.req[i] = nr;
        bus.data[8*i +: 8] = nr ? q_byte[i][q_head[i]] : 8'h00;
        bus.last[i] = nr ? q_last[i][q_head[i]] : 1'b0;
      end
      bus.uart_busy = busy;
    end
  end

  task automatic wait_quiet(input string name, input int budget);
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while (!(queues_empty() && !busy && idle)) begin
      @(negedge clk);
      t++;
      if (t > budget) begin
        chk(name, 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, {28'b0, bus.grant}, 32'd0);
    chk({tag, "_ack"}, {28'b0, bus.ack}, 32'd0);
    chk({tag, "_start"}, {31'b0, bus.uart_start}, 32'd0);
    chk({tag, "_udata"}, {24'b0, bus.uart_data}, 32'd0);
    chk({tag, "_errs"}, {30'b0, err_busy, err_gap}, 32'd0);
    chk({tag, "_idle"}, {31'b0, idle}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    int         n;
    logic [7:0] ord;
  } vec_t;

  vec_t vt [6];

  initial begin
    int base, t, ebase;
    vt[0] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
    vt[1] = '{4'b0010, 1, {6'd0, 2'd1}};
    vt[2] = '{4'b0011, 2, {4'd0, 2'd1, 2'd0}};
    vt[3] = '{4'b1001, 2, {4'd0, 2'd0, 2'd3}};
    vt[4] = '{4'b0101, 2, {4'd0, 2'd0, 2'd2}};
    vt[5] = '{4'b1110, 3, {2'd0, 2'd3, 2'd2, 2'd1}};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;

    // Single-byte rounds; ptr carries over between rows.
    for (int v = 0; v < 6; v++) begin
      base = tx_n;
      for (int i = 0; i < 4; i++) if (vt[v].req[i]) push(i, 8'hA0 + 8'(i), 1'b1);
      wait_quiet("vec_timeout", 2000);
      chk($sformatf("vec%0d_count", v), tx_n - base, vt[v].n);
      for (int k = 0; k < vt[v].n; k++) begin
        logic [1:0] e;
        e = vt[v].ord[2*k +: 2];
        chk($sformatf("vec%0d_byte%0d", v, k), {24'b0, tx_byte[base+k]}, {24'b0, 8'hA0 + 8'(e)});
        chk($sformatf("vec%0d_grant%0d", v, k), {28'b0, tx_grant[base+k]}, {28'b0, 4'b0001 << e});
      end
    end

    // Single byte from requester 1 with latency check.
    base = tx_n;
    push(1, 8'h43, 1'b1);
    wait_quiet("t1_timeout", 500);
    chk("t1_count", tx_n - base, 1);
    chk("t1_byte", {24'b0, tx_byte[base]}, 32'h43);
    chk("t1_grant", {28'b0, tx_grant[base]}, 32'b0010);
    chk("t1_ack", {28'b0, tx_ack[base]}, 32'b0010);
    chk("t1_grant_latency", grant_cyc - req_rise_cyc[1], 1);
    chk("t1_start_latency", tx_cyc[base] - req_rise_cyc[1], 2);
    chk("t1_idle", {31'b0, idle}, 32'd1);

    // Multi-byte frame from 2 holds the UART while requester 0 waits.
    base = tx_n;
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    push(0, 8'h55, 1'b1);
    wait_quiet("t3_timeout", 2000);
    chk("t3_count", tx_n - base, 4);
    chk("t3_b0", {24'b0, tx_byte[base]},   32'h11);
    chk("t3_b1", {24'b0, tx_byte[base+1]}, 32'h22);
    chk("t3_b2", {24'b0, tx_byte[base+2]}, 32'h33);
    chk("t3_b3", {24'b0, tx_byte[base+3]}, 32'h55);
    chk("t3_g2", {28'b0, tx_grant[base+2]}, 32'b0100);
    chk("t3_g3", {28'b0, tx_grant[base+3]}, 32'b0001);

    // UART never goes busy.
    stub = 1'b1;
    base = tx_n;
    ebase = n_eb;
    push(3, 8'h77, 1'b1);
    wait_quiet("t4_timeout", 500);
    chk("t4_err_count", n_eb - ebase, 1);
    chk("t4_err_delay", eb_cyc - tx_cyc[base], 16);
    chk("t4_err_grant", {28'b0, err_grant}, 32'd0);
    chk("t4_ack", {28'b0, tx_ack[base]}, 32'b1000);
    stub = 1'b0;
    base = tx_n;
    push(0, 8'h5A, 1'b1);
    wait_quiet("t4b_timeout", 500);
    chk("t4b_byte", {24'b0, tx_byte[base]}, 32'h5A);
    chk("t4b_grant", {28'b0, tx_grant[base]}, 32'b0001);

    // Owner stops mid-frame; requester 1 must wait for the gap timeout.
    base = tx_n;
    ebase = n_eg;
    push(3, 8'hC1, 1'b0);
    t = 0;
    while (bus.grant != 4'b1000 && t < 50) begin @(negedge clk); t++; end
    chk("t5_grant3", {28'b0, bus.grant}, 32'b1000);
    push(1, 8'hD1, 1'b1);
    wait_quiet("t5_timeout", 3000);
    chk("t5_err_count", n_eg - ebase, 1);
    chk("t5_gap_len", eg_len, 1025);
    chk("t5_err_grant", {28'b0, err_grant}, 32'd0);
    chk("t5_count", tx_n - base, 2);
    chk("t5_b1", {24'b0, tx_byte[base+1]}, 32'hD1);
    chk("t5_after_err", {31'b0, tx_cyc[base+1] > tx_cyc[base] + 1100}, 32'd1);

    // Reset while the owner's byte is shifting.
    push(2, 8'hE2, 1'b1);
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    chk("t6_grant_before", {28'b0, bus.grant}, 32'b0100);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6");
    reset = 1'b1;
    base = tx_n;
    repeat (100) @(negedge clk);
    chk("t6_no_start", tx_n - base, 0);
    chk("t6_still_idle", {31'b0, idle}, 32'd1);
    // Pointer back at 0: requester 1 wins over 2.
    base = tx_n;
    push(1, 8'hB1, 1'b1);
    push(2, 8'hB2, 1'b1);
    wait_quiet("t6b_timeout", 1000);
    chk("t6b_count", tx_n - base, 2);
    chk("t6b_b0", {24'b0, tx_byte[base]},   32'hB1);
    chk("t6b_b1", {24'b0, tx_byte[base+1]}, 32'hB2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
